// File: rtl/approx_pkg.sv
// Shared types and sizing helpers for the approximate dot-product accumulator.
// Holds the FSM state enum, the S1 operand bundle and the accumulator width rule.
package approx_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] x;
    logic [7:0] y;
  } s1_t;

  function automatic int acc_w_min(input int vec_len);
    return PROD_W + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/approx_mul_stage.sv
// S2: approximate and exact 8x8 unsigned products, registered with a valid bit.
// Ports: clk, rst_n, in_vld/in_x/in_y from S1; out_vld/out_approx/out_exact to S3.
module approx_mul8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  // Nibble-split multiplier: the low x low partial product is
  // replaced by a bitwise OR, so the error can go either way.
  logic [7:0] hh;
  logic [8:0] mid;
  logic [3:0] ll;

  assign hh  = {4'b0, a[7:4]} * {4'b0, b[7:4]};
  assign mid = {5'b0, a[7:4]} * {5'b0, b[3:0]}
             + {5'b0, a[3:0]} * {5'b0, b[7:4]};
  assign ll  = a[3:0] | b[3:0];
  assign p   = {hh, 8'b0} + {3'b0, mid, 4'b0} + {12'b0, ll};
endmodule

module approx_mul_stage
  import approx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [7:0]        in_x,
  input  logic [7:0]        in_y,
  output logic              out_vld,
  output logic [PROD_W-1:0] out_approx,
  output logic [PROD_W-1:0] out_exact
);
  logic [PROD_W-1:0] p_approx;
  logic [PROD_W-1:0] p_exact;

  approx_mul8 u_mul (
    .a(in_x),
    .b(in_y),
    .p(p_approx)
  );

  assign p_exact = {8'b0, in_x} * {8'b0, in_y};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld    <= 1'b0;
      out_approx <= '0;
      out_exact  <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_approx <= p_approx;
        out_exact  <= p_exact;
      end
    end
  end
endmodule

// File: rtl/approx_dot_accum.sv
// Streaming dot-product accumulator: approx sum, exact sum and abs error per vector.
// Ports: in_valid/in_ready/in_x/in_y operand stream; out_valid/out_ready/out_acc_* result.
module approx_dot_accum
  import approx_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc_approx,
  output logic [ACC_W-1:0] out_acc_exact,
  output logic [ACC_W-1:0] out_err_abs
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int PAD   = ACC_W - PROD_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  if (VEC_LEN < 2) begin : g_len_chk
    $error("VEC_LEN must be at least 2");
  end
  if (ACC_W < acc_w_min(VEC_LEN)) begin : g_acc_chk
    $error("ACC_W too narrow for VEC_LEN");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  s1_t               s1_q;
  logic              s2_vld;
  logic [PROD_W-1:0] s2_approx;
  logic [PROD_W-1:0] s2_exact;
  logic [PROD_W-1:0] diff;
  logic              accept;
  logic              hs;

  assign accept = in_valid & in_ready;
  assign hs     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q.vld <= accept;
      if (accept) begin
        s1_q.x <= in_x;
        s1_q.y <= in_y;
      end
    end
  end

  approx_mul_stage u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (s1_q.vld),
    .in_x      (s1_q.x),
    .in_y      (s1_q.y),
    .out_vld   (s2_vld),
    .out_approx(s2_approx),
    .out_exact (s2_exact)
  );

  always_comb begin
    diff = '0;
    if (s2_exact >= s2_approx) diff = s2_exact - s2_approx;
    else                       diff = s2_approx - s2_exact;
  end

  // In DRAIN the last product sits in S2 once S1 has emptied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= ACCUM;
            cnt   <= CNT_W'(1);
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (s2_vld && !s1_q.vld) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_acc_approx <= '0;
      out_acc_exact  <= '0;
      out_err_abs    <= '0;
    end else if (hs) begin
      out_acc_approx <= '0;
      out_acc_exact  <= '0;
      out_err_abs    <= '0;
    end else if (s2_vld) begin
      out_acc_approx <= out_acc_approx + {{PAD{1'b0}}, s2_approx};
      out_acc_exact  <= out_acc_exact + {{PAD{1'b0}}, s2_exact};
      out_err_abs    <= out_err_abs + {{PAD{1'b0}}, diff};
    end
  end

endmodule

// File: tb/tb_approx_dot_accum.sv
// Self-checking bench for approx_dot_accum: table vectors, random streams,
// back-to-back, reset abort and exhaustive operand sweep against a reference model.
module tb_approx_dot_accum;
  localparam int N  = 16;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_x = '0;
  logic [7:0]    in_y = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_acc_approx;
  logic [AW-1:0] out_acc_exact;
  logic [AW-1:0] out_err_abs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_dot_accum #(.VEC_LEN(N), .ACC_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_x          (in_x),
    .in_y          (in_y),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_acc_approx(out_acc_approx),
    .out_acc_exact (out_acc_exact),
    .out_err_abs   (out_err_abs)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         ea;
    int         ee;
    int         er;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] qx[$];
  logic [7:0] qy[$];
  longint     ra, re, rr;

  // Reference: exact product with the low-nibble partial product
  // swapped for the OR of the low nibbles.
  function automatic int mul_approx(input int x, input int y);
    int xl = x % 16;
    int yl = y % 16;
    return x * y - xl * yl + (xl | yl);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input bit rand_valid, input int hold, input bit b2b);
    int     nvec = qx.size() / N;
    int     sent = 0;
    int     got = 0;
    int     t = 0;
    int     last_acc = -100;
    int     hcnt = 0;
    int     limit;
    longint sa = 0, se = 0, sr = 0;
    bit     pos = 1'b1, neg = 1'b1;
    longint ea[$], ee[$], er[$];
    bit     same[$];
    bit     a, o, pv;
    logic [AW-1:0] pa, pe, pr;
    limit = nvec * N * 4 + nvec * (hold + 8) + 40;
    in_valid = qx.size() > 0 && (!rand_valid || $urandom_range(1, 0) == 1);
    if (qx.size() > 0) begin
      in_x = qx[0];
      in_y = qy[0];
    end
    out_ready = (hold == 0);
    while (got < nvec && t < limit) begin
      a  = in_valid && in_ready;
      o  = out_valid && out_ready;
      pv = out_valid;
      pa = out_acc_approx;
      pe = out_acc_exact;
      pr = out_err_abs;
      @(posedge clk);
      #1;
      t++;
      if (a) begin
        int ap, ex;
        ap = mul_approx(int'(in_x), int'(in_y));
        ex = int'(in_x) * int'(in_y);
        sent++;
        if (b2b && sent % N == 1 && sent > 1)
          chk("b2b_gap", t - last_acc, 4);
        last_acc = t;
        sa += ap;
        se += ex;
        sr += (ex > ap) ? ex - ap : ap - ex;
        if (ex < ap) pos = 1'b0;
        if (ex > ap) neg = 1'b0;
        if (sent % N == 0) begin
          ea.push_back(sa);
          ee.push_back(se);
          er.push_back(sr);
          same.push_back(pos || neg);
          sa = 0; se = 0; sr = 0;
          pos = 1'b1; neg = 1'b1;
        end
        void'(qx.pop_front());
        void'(qy.pop_front());
      end
      if (o) begin
        if (ea.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("acc_approx", pa, ea.pop_front());
          chk("acc_exact", pe, ee.pop_front());
          chk("err_abs", pr, er.pop_front());
          if (same.pop_front())
            chk("diff_mag", (pe > pa) ? pe - pa : pa - pe, pr);
        end
        ra = pa; re = pe; rr = pr;
        got++;
        chk("post_hs_ready", in_ready, 1);
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_clear", out_acc_exact | out_acc_approx | out_err_abs, 0);
      end else if (pv) begin
        chk("hold_stable", (out_valid && out_acc_approx == pa &&
            out_acc_exact == pe && out_err_abs == pr), 1);
        chk("hold_ready", in_ready, 0);
      end
      if (out_valid && !pv) begin
        chk("latency", t - last_acc, 2);
        chk("drain_ready", in_ready, 0);
      end
      in_valid = qx.size() > 0 && (!rand_valid || $urandom_range(1, 0) == 1);
      if (qx.size() > 0) begin
        in_x = qx[0];
        in_y = qy[0];
      end
      if (out_valid) begin
        out_ready = (hcnt >= hold);
        hcnt++;
      end else begin
        out_ready = (hold == 0);
        hcnt = 0;
      end
    end
    chk("vectors_done", got, nvec);
    chk("pairs_left", qx.size(), 0);
    in_valid = 1'b0;
    qx.delete();
    qy.delete();
  endtask

  initial begin
    int seen;
    tbl[0] = '{8'd0,   8'd0,   0,       0,       0};
    tbl[1] = '{8'd255, 8'd255, 1037040, 1040400, 3360};
    tbl[2] = '{8'd1,   8'd1,   16,      16,      0};
    tbl[3] = '{8'd15,  8'd15,  240,     3600,    3360};
    tbl[4] = '{8'd16,  8'd16,  4096,    4096,    0};
    tbl[5] = '{8'd0,   8'd15,  240,     0,       240};
    tbl[6] = '{8'd3,   8'd5,   112,     240,     128};
    tbl[7] = '{8'd170, 8'd85,  230640,  231200,  560};

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", out_acc_approx | out_acc_exact | out_err_abs, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      repeat (N) begin
        qx.push_back(tbl[i].x);
        qy.push_back(tbl[i].y);
      end
      run(1'b0, 0, 1'b0);
      chk("tbl_approx", ra, tbl[i].ea);
      chk("tbl_exact", re, tbl[i].ee);
      chk("tbl_err", rr, tbl[i].er);
    end

    for (int v = 0; v < 3; v++) begin
      repeat (N) begin
        qx.push_back(8'($urandom));
        qy.push_back(8'($urandom));
      end
      run(1'b1, 10, 1'b0);
    end

    repeat (3 * N) begin
      qx.push_back(8'($urandom));
      qy.push_back(8'($urandom));
    end
    run(1'b0, 0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_x = 8'($urandom);
      in_y = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_acc", out_acc_approx | out_acc_exact | out_err_abs, 0);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_out", seen, 0);
    repeat (N) begin
      qx.push_back(8'($urandom));
      qy.push_back(8'($urandom));
    end
    run(1'b1, 0, 1'b0);

    for (int i = 0; i < 65536; i++) begin
      qx.push_back(8'(i >> 8));
      qy.push_back(8'(i & 255));
    end
    run(1'b0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
